// File: rtl/syncgen_cfg.sv
// Runtime-reconfigurable video timing generator. New timing sets are validated
// on acceptance and only swapped into the live registers at a frame boundary.
module syncgen_cfg #(
  parameter int CW             = 12,
  parameter int H_TOTAL        = 1800,
  parameter int H_SYNC         = 80,
  parameter int H_BACKP        = 96,
  parameter int H_ACTIVE       = 1600,
  parameter int V_TOTAL        = 1000,
  parameter int V_SYNC         = 3,
  parameter int V_BACKP        = 96,
  parameter int V_ACTIVE       = 900,
  parameter int HSYNC_POL      = 1,
  parameter int VSYNC_POL      = 1,
  parameter int PREFETCH_LINES = 6
) (
  input  logic          video_clk,
  input  logic          reset_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_h_total,
  input  logic [CW-1:0] cfg_h_sync,
  input  logic [CW-1:0] cfg_h_backp,
  input  logic [CW-1:0] cfg_h_active,
  input  logic [CW-1:0] cfg_v_total,
  input  logic [CW-1:0] cfg_v_sync,
  input  logic [CW-1:0] cfg_v_backp,
  input  logic [CW-1:0] cfg_v_active,
  output logic          cfg_error,
  output logic          cfg_applied,
  output logic          framestart,
  output logic          linestart,
  output logic          prefetch_line,
  output logic          pixelena,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y
);
  localparam int EW = CW + 2;
  localparam logic HS_INV = (HSYNC_POL == 0);
  localparam logic VS_INV = (VSYNC_POL == 0);
  localparam logic [EW-1:0] PF = EW'(PREFETCH_LINES);

  typedef struct packed {
    logic [CW-1:0] ht;
    logic [CW-1:0] hs;
    logic [CW-1:0] hb;
    logic [CW-1:0] ha;
    logic [CW-1:0] vt;
    logic [CW-1:0] vs;
    logic [CW-1:0] vb;
    logic [CW-1:0] va;
  } timing_t;

  localparam timing_t DEFAULTS = '{ht: CW'(H_TOTAL), hs: CW'(H_SYNC), hb: CW'(H_BACKP),
                                   ha: CW'(H_ACTIVE), vt: CW'(V_TOTAL), vs: CW'(V_SYNC),
                                   vb: CW'(V_BACKP), va: CW'(V_ACTIVE)};

  function automatic logic [EW-1:0] ext(input logic [CW-1:0] a);
    return {2'b00, a};
  endfunction

  timing_t       live_q, live_d, shadow_q, shadow_d, cfg_in;
  logic [CW-1:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic          pending_q, pending_d, cfg_error_q, cfg_error_d, cfg_applied_q, cfg_applied_d;
  logic          framestart_q, framestart_d, linestart_q, linestart_d;
  logic          prefetch_q, prefetch_d, pixelena_q, pixelena_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, hblank_q, hblank_d, vblank_q, vblank_d;

  logic [EW-1:0] cfg_h_need, cfg_v_fp, cfg_v_need, h_start, h_end, v_start, v_end;
  logic [CW-1:0] prefetch_v;
  logic          cfg_ok, accept, apply, last_h, last_v, h_act, v_act;

  assign cfg_in = '{ht: cfg_h_total, hs: cfg_h_sync, hb: cfg_h_backp, ha: cfg_h_active,
                    vt: cfg_v_total, vs: cfg_v_sync, vb: cfg_v_backp, va: cfg_v_active};

  // Sums are widened by two bits so that oversized fields cannot wrap and pass.
  assign cfg_h_need = ext(cfg_h_sync) + ext(cfg_h_backp) + ext(cfg_h_active);
  assign cfg_v_fp   = ext(cfg_v_sync) + ext(cfg_v_backp);
  assign cfg_v_need = cfg_v_fp + ext(cfg_v_active);
  assign cfg_ok = (cfg_h_need <= ext(cfg_h_total)) && (cfg_v_need <= ext(cfg_v_total)) &&
                  (cfg_h_total >= CW'(2)) && (cfg_v_total >= CW'(2)) &&
                  (cfg_h_sync != '0) && (cfg_h_active != '0) && (cfg_v_active != '0) &&
                  (cfg_v_fp >= PF);
  assign accept = cfg_valid && !pending_q;

  assign h_start    = ext(live_q.hs) + ext(live_q.hb);
  assign h_end      = h_start + ext(live_q.ha);
  assign v_start    = ext(live_q.vs) + ext(live_q.vb);
  assign v_end      = v_start + ext(live_q.va);
  assign h_act      = (ext(h_q) >= h_start) && (ext(h_q) < h_end);
  assign v_act      = (ext(v_q) >= v_start) && (ext(v_q) < v_end);
  assign prefetch_v = v_start[CW-1:0] - PF[CW-1:0];
  assign last_h     = (h_q == live_q.ht - CW'(1));
  assign last_v     = (v_q == live_q.vt - CW'(1));
  assign apply      = pending_q && last_h && last_v;

  always_comb begin
    h_d = last_h ? '0 : h_q + CW'(1);
    v_d = v_q;
    if (last_h) v_d = last_v ? '0 : v_q + CW'(1);
    live_d    = apply ? shadow_q : live_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (accept && cfg_ok) begin
      shadow_d  = cfg_in;
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
    cfg_error_d   = accept && !cfg_ok;
    cfg_applied_d = apply;
    framestart_d  = (h_q == '0) && (v_q == '0);
    linestart_d   = (h_q == '0) && v_act;
    prefetch_d    = (v_q == prefetch_v);
    pixelena_d    = h_act && v_act;
    hsync_d       = (h_q < live_q.hs) ^ HS_INV;
    vsync_d       = (v_q < live_q.vs) ^ VS_INV;
    hblank_d      = !h_act;
    vblank_d      = !v_act;
    x_d           = pixelena_d ? h_q - h_start[CW-1:0] : '0;
    y_d           = pixelena_d ? v_q - v_start[CW-1:0] : '0;
  end

  always_ff @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q           <= '0;
      v_q           <= '0;
      live_q        <= DEFAULTS;
      shadow_q      <= DEFAULTS;
      pending_q     <= 1'b0;
      cfg_error_q   <= 1'b0;
      cfg_applied_q <= 1'b0;
      framestart_q  <= 1'b0;
      linestart_q   <= 1'b0;
      prefetch_q    <= 1'b0;
      pixelena_q    <= 1'b0;
      hsync_q       <= HS_INV;
      vsync_q       <= VS_INV;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      live_q        <= live_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      cfg_error_q   <= cfg_error_d;
      cfg_applied_q <= cfg_applied_d;
      framestart_q  <= framestart_d;
      linestart_q   <= linestart_d;
      prefetch_q    <= prefetch_d;
      pixelena_q    <= pixelena_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      x_q           <= x_d;
      y_q           <= y_d;
    end
  end

  assign cfg_ready     = !pending_q;
  assign cfg_error     = cfg_error_q;
  assign cfg_applied   = cfg_applied_q;
  assign framestart    = framestart_q;
  assign linestart     = linestart_q;
  assign prefetch_line = prefetch_q;
  assign pixelena      = pixelena_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign hblank        = hblank_q;
  assign vblank        = vblank_q;
  assign x             = x_q;
  assign y             = y_q;
endmodule

// File: tb/tb_syncgen_cfg.sv
// Bench for syncgen_cfg using a reduced 40x20 reset timing so that several frame
// boundaries, config swaps and a mid-frame reset fit into a short run.
module tb_syncgen_cfg;
  localparam int CW = 12;

  logic          video_clk = 1'b0;
  logic          reset_n;
  logic          cfg_valid;
  logic [CW-1:0] cfg_h_total, cfg_h_sync, cfg_h_backp, cfg_h_active;
  logic [CW-1:0] cfg_v_total, cfg_v_sync, cfg_v_backp, cfg_v_active;

  logic          cfg_ready, cfg_error, cfg_applied, framestart, linestart, prefetch_line;
  logic          pixelena, hsync, vsync, hblank, vblank;
  logic [CW-1:0] x, y;

  logic          cfg_ready_p0, cfg_error_p0, cfg_applied_p0, framestart_p0, linestart_p0;
  logic          prefetch_line_p0, pixelena_p0, hsync_p0, vsync_p0, hblank_p0, vblank_p0;
  logic [CW-1:0] x_p0, y_p0;

  int cyc;
  int checks = 0;
  int errors = 0;
  int fs_q[$];
  int ap_q[$];
  int er_q[$];

  syncgen_cfg #(
    .CW(CW), .H_TOTAL(40), .H_SYNC(4), .H_BACKP(6), .H_ACTIVE(24),
    .V_TOTAL(20), .V_SYNC(2), .V_BACKP(8), .V_ACTIVE(8),
    .HSYNC_POL(1), .VSYNC_POL(1), .PREFETCH_LINES(6)
  ) u_dut (
    .video_clk(video_clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync), .cfg_h_backp(cfg_h_backp),
    .cfg_h_active(cfg_h_active), .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
    .cfg_v_backp(cfg_v_backp), .cfg_v_active(cfg_v_active), .cfg_error(cfg_error),
    .cfg_applied(cfg_applied), .framestart(framestart), .linestart(linestart),
    .prefetch_line(prefetch_line), .pixelena(pixelena), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .x(x), .y(y)
  );

  // Same timing with both sync polarities flipped.
  syncgen_cfg #(
    .CW(CW), .H_TOTAL(40), .H_SYNC(4), .H_BACKP(6), .H_ACTIVE(24),
    .V_TOTAL(20), .V_SYNC(2), .V_BACKP(8), .V_ACTIVE(8),
    .HSYNC_POL(0), .VSYNC_POL(0), .PREFETCH_LINES(6)
  ) u_inv (
    .video_clk(video_clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_p0),
    .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync), .cfg_h_backp(cfg_h_backp),
    .cfg_h_active(cfg_h_active), .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
    .cfg_v_backp(cfg_v_backp), .cfg_v_active(cfg_v_active), .cfg_error(cfg_error_p0),
    .cfg_applied(cfg_applied_p0), .framestart(framestart_p0), .linestart(linestart_p0),
    .prefetch_line(prefetch_line_p0), .pixelena(pixelena_p0), .hsync(hsync_p0),
    .vsync(vsync_p0), .hblank(hblank_p0), .vblank(vblank_p0), .x(x_p0), .y(y_p0)
  );

  always #5 video_clk = ~video_clk;

  // Cycle k is the interval after the k-th rising edge following reset release.
  always @(posedge video_clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic unexpectedPulse(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at cycle %0d: got an unexpected pulse, expected none", name, cyc);
  endtask

  task automatic applyStimulus(input logic valid, input int ht, input int hs, input int hb,
                               input int ha, input int vt, input int vs, input int vb,
                               input int va);
    cfg_valid    = valid;
    cfg_h_total  = CW'(ht);
    cfg_h_sync   = CW'(hs);
    cfg_h_backp  = CW'(hb);
    cfg_h_active = CW'(ha);
    cfg_v_total  = CW'(vt);
    cfg_v_sync   = CW'(vs);
    cfg_v_backp  = CW'(vb);
    cfg_v_active = CW'(va);
  endtask

  task automatic waitCycle(input int k);
    int n = 0;
    while (cyc != k && n < 5000) begin
      @(negedge video_clk);
      n++;
    end
    if (cyc != k) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitCycle: reached cycle %0d, expected %0d", cyc, k);
    end
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_flags"},
                {19'd0, cfg_ready, cfg_error, cfg_applied, framestart, linestart, prefetch_line,
                 pixelena, hblank, vblank, hsync, vsync, hsync_p0, vsync_p0},
                32'b1000000110011);
    checkOutput({name, "_xy"}, {8'd0, x, y}, 32'd0);
  endtask

  // Scoreboard monitor: every pulse pops the next expected cycle for its kind.
  always @(negedge video_clk) begin
    if (framestart) begin
      if (fs_q.size() == 0) unexpectedPulse("framestart");
      else checkOutput("framestart_cycle", cyc, fs_q.pop_front());
    end
    if (cfg_applied) begin
      if (ap_q.size() == 0) unexpectedPulse("cfg_applied");
      else checkOutput("cfg_applied_cycle", cyc, ap_q.pop_front());
    end
    if (cfg_error) begin
      if (er_q.size() == 0) unexpectedPulse("cfg_error");
      else checkOutput("cfg_error_cycle", cyc, er_q.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge video_clk);
    checkResetState("reset_initial");
    fs_q.push_back(1);
    fs_q.push_back(801);
    reset_n = 1'b1;

    // Reset timing: 40x20, hs=4 hb=6 ha=24, vs=2 vb=8 va=8, prefetch line 4.
    waitCycle(1);
    checkOutput("hsync_c1", hsync, 1);
    checkOutput("vsync_c1", vsync, 1);
    checkOutput("hblank_c1", hblank, 1);
    checkOutput("hsync_inv_c1", hsync_p0, 0);
    checkOutput("vsync_inv_c1", vsync_p0, 0);
    waitCycle(4);   checkOutput("hsync_c4", hsync, 1);
    waitCycle(5);   checkOutput("hsync_c5", hsync, 0);
                    checkOutput("hsync_inv_c5", hsync_p0, 1);
    waitCycle(10);  checkOutput("hblank_c10", hblank, 1);
    waitCycle(11);  checkOutput("hblank_c11", hblank, 0);
    waitCycle(80);  checkOutput("vsync_c80", vsync, 1);
    waitCycle(81);  checkOutput("vsync_c81", vsync, 0);
                    checkOutput("vsync_inv_c81", vsync_p0, 1);
    waitCycle(160); checkOutput("prefetch_c160", prefetch_line, 0);
    waitCycle(161); checkOutput("prefetch_c161", prefetch_line, 1);
    waitCycle(200); checkOutput("prefetch_c200", prefetch_line, 1);
    waitCycle(201); checkOutput("prefetch_c201", prefetch_line, 0);
    waitCycle(401); checkOutput("linestart_c401", linestart, 1);
    waitCycle(402); checkOutput("linestart_c402", linestart, 0);
    waitCycle(410); checkOutput("pixelena_c410", pixelena, 0);
    waitCycle(411); checkOutput("pixelena_first", pixelena, 1);
                    checkOutput("xy_first", {8'd0, x, y}, {8'd0, 12'd0, 12'd0});
    waitCycle(714); checkOutput("pixelena_last", pixelena, 1);
                    checkOutput("xy_last", {8'd0, x, y}, {8'd0, 12'd23, 12'd7});
    waitCycle(715); checkOutput("pixelena_c715", pixelena, 0);
                    checkOutput("xy_c715", {8'd0, x, y}, 32'd0);

    // Valid set offered mid-frame; old timing runs on until cycle 1600.
    waitCycle(900);
    fs_q.push_back(1601);
    fs_q.push_back(1801);
    fs_q.push_back(2001);
    fs_q.push_back(2201);
    ap_q.push_back(1600);
    ap_q.push_back(1800);
    applyStimulus(1'b1, 20, 2, 3, 10, 10, 1, 6, 2);
    waitCycle(901);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ready_pending", cfg_ready, 0);
    waitCycle(1000);
    applyStimulus(1'b1, 20, 2, 3, 10, 10, 1, 6, 2);
    waitCycle(1211); checkOutput("old_timing_pixel", pixelena, 1);
                     checkOutput("old_timing_xy", {8'd0, x, y}, 32'd0);
    waitCycle(1599); checkOutput("ready_c1599", cfg_ready, 0);
    waitCycle(1600); checkOutput("ready_c1600", cfg_ready, 1);
    waitCycle(1601);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ready_second_accepted", cfg_ready, 0);
    checkOutput("new_hsync_c1601", hsync, 1);
    waitCycle(1602); checkOutput("new_hsync_c1602", hsync, 1);
    waitCycle(1603); checkOutput("new_hsync_c1603", hsync, 0);
    waitCycle(1620); checkOutput("new_prefetch_c1620", prefetch_line, 0);
    waitCycle(1621); checkOutput("new_prefetch_c1621", prefetch_line, 1);
                     checkOutput("new_line_period", hsync, 1);
    waitCycle(1640); checkOutput("new_prefetch_c1640", prefetch_line, 1);
    waitCycle(1641); checkOutput("new_prefetch_c1641", prefetch_line, 0);
    waitCycle(1745); checkOutput("new_pixelena_c1745", pixelena, 0);
    waitCycle(1746); checkOutput("new_pixelena_first", pixelena, 1);
                     checkOutput("new_xy_first", {8'd0, x, y}, 32'd0);
    waitCycle(1775); checkOutput("new_pixelena_last", pixelena, 1);
                     checkOutput("new_xy_last", {8'd0, x, y}, {8'd0, 12'd9, 12'd1});
    waitCycle(1776); checkOutput("new_pixelena_c1776", pixelena, 0);
    waitCycle(1799); checkOutput("ready_c1799", cfg_ready, 0);
    waitCycle(1800); checkOutput("ready_c1800", cfg_ready, 1);

    // Rejected sets: active overflows total, then sync+backporch below prefetch.
    waitCycle(1900);
    er_q.push_back(1901);
    applyStimulus(1'b1, 20, 2, 1, 19, 10, 1, 6, 2);
    waitCycle(1901);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ready_after_reject1", cfg_ready, 1);
    waitCycle(1950);
    er_q.push_back(1951);
    applyStimulus(1'b1, 20, 2, 3, 10, 10, 1, 2, 2);
    waitCycle(1951);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ready_after_reject2", cfg_ready, 1);
    waitCycle(2146); checkOutput("timing_kept_pixel", pixelena, 1);
                     checkOutput("timing_kept_xy", {8'd0, x, y}, 32'd0);

    // Reset with a set pending: discarded, reset timing resumes, no apply.
    waitCycle(2200);
    applyStimulus(1'b1, 30, 3, 4, 20, 12, 2, 5, 3);
    waitCycle(2201);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ready_pending2", cfg_ready, 0);
    waitCycle(2250);
    reset_n = 1'b0;
    #1;
    checkResetState("reset_pending");
    repeat (2) @(negedge video_clk);
    fs_q.push_back(1);
    fs_q.push_back(801);
    reset_n = 1'b1;
    waitCycle(10);  checkOutput("rst_hblank_c10", hblank, 1);
    waitCycle(11);  checkOutput("rst_hblank_c11", hblank, 0);
    waitCycle(411); checkOutput("rst_pixelena_first", pixelena, 1);
                    checkOutput("rst_xy_first", {8'd0, x, y}, 32'd0);
    waitCycle(801); checkOutput("rst_ready_c801", cfg_ready, 1);
    waitCycle(810);

    checkOutput("framestart_missing", fs_q.size(), 0);
    checkOutput("cfg_applied_missing", ap_q.size(), 0);
    checkOutput("cfg_error_missing", er_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
